// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake, optional 2-entry skid
// buffer, flush (priority over stall) and an occupancy count for the flow controller.
module pipe_stage_reg #(
  parameter int unsigned        DATA_W       = 32,
  parameter bit                 SKID         = 1'b1,
  parameter logic [DATA_W-1:0]  RST_VAL      = '0,
  parameter bit                 CLR_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [1:0]        occ_o
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              up_fire, dn_fire;

  assign dn_fire = main_valid_q & dn_ready_i & ~stall_i;
  assign up_fire = up_valid_i & up_ready_o;

  // With the skid buffer, ready depends only on state, cutting the path from dn_ready_i.
  if (SKID) begin : g_ready_skid
    assign up_ready_o = ~skid_valid_q & ~flush_i;
  end else begin : g_ready_comb
    assign up_ready_o = (~main_valid_q | dn_fire) & ~flush_i;
  end

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      if (CLR_ON_FLUSH) begin
        main_data_d = RST_VAL;
        skid_data_d = RST_VAL;
      end
    end else if (skid_valid_q) begin
      if (dn_fire) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (up_fire && dn_fire) begin
        main_data_d = up_data_i;
      end else if (up_fire) begin
        // Only reachable with SKID=1; SKID=0 never accepts into a full stage without a drain.
        skid_valid_d = 1'b1;
        skid_data_d  = up_data_i;
      end else if (dn_fire) begin
        main_valid_d = 1'b0;
      end
    end else if (up_fire) begin
      main_valid_d = 1'b1;
      main_data_d  = up_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= RST_VAL;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
    end
  end

  if (SKID) begin : g_skid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        skid_valid_q <= 1'b0;
        skid_data_q  <= RST_VAL;
      end else begin
        skid_valid_q <= skid_valid_d;
        skid_data_q  <= skid_data_d;
      end
    end
  end else begin : g_no_skid
    assign skid_valid_q = 1'b0;
    assign skid_data_q  = RST_VAL;
  end

  assign dn_valid_o = main_valid_q;
  assign dn_data_o  = main_data_q;
  assign occ_o      = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations checked every cycle against a queue model,
// plus directed literal expectations.
module tb_pipe_stage_reg;

  localparam logic [31:0] RV0 = 32'h5A5A_0000;
  localparam logic [31:0] RV1 = 32'h0000_00FF;
  localparam logic [63:0] RV2 = 64'h0000_0000_0000_0001;

  logic clk, rst_n;
  logic        up_valid [3];
  logic        dn_ready [3];
  logic        stall    [3];
  logic        flush    [3];
  logic [63:0] up_data  [3];
  logic        up_ready [3];
  logic        dn_valid [3];
  logic [1:0]  occ      [3];
  logic [63:0] dn_data  [3];

  logic        rdy0, rdy1, rdy2, vld0, vld1, vld2;
  logic [1:0]  occ0, occ1, occ2;
  logic [31:0] dat0, dat1;
  logic [63:0] dat2;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(32), .SKID(1'b1), .RST_VAL(RV0), .CLR_ON_FLUSH(1'b1)) u_skid (
    .clk(clk), .rst_n(rst_n), .up_valid_i(up_valid[0]), .up_ready_o(rdy0),
    .up_data_i(up_data[0][31:0]), .dn_valid_o(vld0), .dn_ready_i(dn_ready[0]),
    .dn_data_o(dat0), .stall_i(stall[0]), .flush_i(flush[0]), .occ_o(occ0)
  );
  pipe_stage_reg #(.DATA_W(32), .SKID(1'b0), .RST_VAL(RV1), .CLR_ON_FLUSH(1'b1)) u_noskid (
    .clk(clk), .rst_n(rst_n), .up_valid_i(up_valid[1]), .up_ready_o(rdy1),
    .up_data_i(up_data[1][31:0]), .dn_valid_o(vld1), .dn_ready_i(dn_ready[1]),
    .dn_data_o(dat1), .stall_i(stall[1]), .flush_i(flush[1]), .occ_o(occ1)
  );
  pipe_stage_reg #(.DATA_W(64), .SKID(1'b1), .RST_VAL(RV2), .CLR_ON_FLUSH(1'b0)) u_wide (
    .clk(clk), .rst_n(rst_n), .up_valid_i(up_valid[2]), .up_ready_o(rdy2),
    .up_data_i(up_data[2]), .dn_valid_o(vld2), .dn_ready_i(dn_ready[2]),
    .dn_data_o(dat2), .stall_i(stall[2]), .flush_i(flush[2]), .occ_o(occ2)
  );

  assign up_ready[0] = rdy0;
  assign up_ready[1] = rdy1;
  assign up_ready[2] = rdy2;
  assign dn_valid[0] = vld0;
  assign dn_valid[1] = vld1;
  assign dn_valid[2] = vld2;
  assign occ[0] = occ0;
  assign occ[1] = occ1;
  assign occ[2] = occ2;
  assign dn_data[0] = {32'h0, dat0};
  assign dn_data[1] = {32'h0, dat1};
  assign dn_data[2] = dat2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: an in-order queue of held beats; dn_data shows the head, or the last payload
  // left in the output register when empty.
  logic [63:0] mdat  [3][2];
  int          mcnt  [3];
  logic [63:0] mlast [3];

  function automatic logic [63:0] rv(int i);
    if (i == 0) return {32'h0, RV0};
    if (i == 1) return {32'h0, RV1};
    return RV2;
  endfunction

  function automatic logic exp_dn_fire(int i);
    return (mcnt[i] > 0) && dn_ready[i] && !stall[i];
  endfunction

  function automatic logic exp_ready(int i);
    if (flush[i]) return 1'b0;
    if (i == 1) return (mcnt[i] == 0) || exp_dn_fire(i);
    return mcnt[i] < 2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mcnt[i]  = 0;
        mlast[i] = rv(i);
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        automatic logic upf = up_valid[i] && exp_ready(i);
        automatic logic dnf = exp_dn_fire(i);
        if (flush[i]) begin
          if (i != 2) mlast[i] = rv(i);
          else if (mcnt[i] > 0) mlast[i] = mdat[i][0];
          mcnt[i] = 0;
        end else begin
          if (dnf) begin
            mlast[i]   = mdat[i][0];
            mdat[i][0] = mdat[i][1];
            mcnt[i]    = mcnt[i] - 1;
          end
          if (upf) begin
            mdat[i][mcnt[i]] = up_data[i];
            mcnt[i]          = mcnt[i] + 1;
          end
        end
      end
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model_dn_valid[%0d]", i), 64'(dn_valid[i]), 64'(mcnt[i] > 0));
      check($sformatf("model_occ[%0d]", i), 64'(occ[i]), 64'(mcnt[i]));
      check($sformatf("model_up_ready[%0d]", i), 64'(up_ready[i]), 64'(exp_ready(i)));
      check($sformatf("model_dn_data[%0d]", i), dn_data[i],
            (mcnt[i] > 0) ? mdat[i][0] : mlast[i]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up_valid[i] = 1'b0;
      dn_ready[i] = 1'b0;
      stall[i]    = 1'b0;
      flush[i]    = 1'b0;
      up_data[i]  = '0;
    end
    #12;
    check("rst_dn_data0", dn_data[0], 64'h5A5A_0000);
    check("rst_dn_data1", dn_data[1], 64'hFF);
    check("rst_dn_valid0", 64'(dn_valid[0]), 64'd0);
    check("rst_up_ready0", 64'(up_ready[0]), 64'd1);
    check("rst_up_ready1", 64'(up_ready[1]), 64'd1);
    rst_n = 1'b1;
    step();

    // Streaming through the skid configuration.
    dn_ready[0] = 1'b1;
    up_valid[0] = 1'b1;
    up_data[0] = 64'h11; step();
    check("stream_d11", dn_data[0], 64'h11);
    check("stream_occ", 64'(occ[0]), 64'd1);
    up_data[0] = 64'h22; step();
    check("stream_d22", dn_data[0], 64'h22);
    check("stream_rdy", 64'(up_ready[0]), 64'd1);
    up_data[0] = 64'h33; step();
    check("stream_d33", dn_data[0], 64'h33);
    up_valid[0] = 1'b0; step();
    check("stream_drain_occ", 64'(occ[0]), 64'd0);

    // Backpressure fills the skid entry; drain order must be A then B.
    dn_ready[0] = 1'b0;
    up_valid[0] = 1'b1;
    up_data[0] = 64'hA; step();
    up_data[0] = 64'hB; step();
    check("bp_occ2", 64'(occ[0]), 64'd2);
    check("bp_rdy0", 64'(up_ready[0]), 64'd0);
    check("bp_headA", dn_data[0], 64'hA);
    up_valid[0] = 1'b0;
    dn_ready[0] = 1'b1; step();
    check("bp_headB", dn_data[0], 64'hB);
    check("bp_occ1", 64'(occ[0]), 64'd1);
    step();
    check("bp_occ0", 64'(occ[0]), 64'd0);

    // Stall versus fill without skid buffer.
    dn_ready[1] = 1'b1;
    up_valid[1] = 1'b1;
    up_data[1] = 64'h5; step();
    stall[1] = 1'b1;
    up_data[1] = 64'h6;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_rdy", 64'(up_ready[1]), 64'd0);
      step();
      check("stall_hold", dn_data[1], 64'h5);
      check("stall_occ", 64'(occ[1]), 64'd1);
    end
    stall[1] = 1'b0;
    #1;
    check("release_rdy", 64'(up_ready[1]), 64'd1);
    step();
    check("release_next", dn_data[1], 64'h6);
    up_valid[1] = 1'b0; step();
    check("release_occ", 64'(occ[1]), 64'd0);

    // Flush with stall while full.
    stall[0] = 1'b1;
    up_valid[0] = 1'b1;
    up_data[0] = 64'hC1; step();
    up_data[0] = 64'hC2; step();
    check("fl_occ2", 64'(occ[0]), 64'd2);
    flush[0] = 1'b1;
    #1;
    check("fl_rdy", 64'(up_ready[0]), 64'd0);
    step();
    flush[0] = 1'b0;
    up_valid[0] = 1'b0;
    stall[0] = 1'b0;
    check("fl_valid", 64'(dn_valid[0]), 64'd0);
    check("fl_occ0", 64'(occ[0]), 64'd0);
    check("fl_data", dn_data[0], 64'h5A5A_0000);
    step();

    // Flush keeps payload when clearing is disabled.
    up_valid[2] = 1'b1;
    up_data[2] = 64'hDEADBEEF_CAFEF00D; step();
    up_valid[2] = 1'b0;
    flush[2] = 1'b1; step();
    flush[2] = 1'b0;
    check("keep_valid", 64'(dn_valid[2]), 64'd0);
    check("keep_data", dn_data[2], 64'hDEADBEEF_CAFEF00D);
    step();

    // Async reset between edges.
    up_valid[0] = 1'b1;
    up_data[0] = 64'h77; step();
    up_valid[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(dn_valid[0]), 64'd0);
    check("arst_occ", 64'(occ[0]), 64'd0);
    check("arst_data", dn_data[0], 64'h5A5A_0000);
    check("arst_wide", dn_data[2], 64'h1);
    #3 rst_n = 1'b1;
    up_valid[0] = 1'b1;
    up_data[0] = 64'h88; step();
    check("post_rst_data", dn_data[0], 64'h88);
    check("post_rst_valid", 64'(dn_valid[0]), 64'd1);
    up_valid[0] = 1'b0; step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline-stage register for the core. It is the successor to the fixed-field inter-stage registers: one instance per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), with the payload packed into one bus.
- Adds a valid/ready handshake, an optional 2-entry skid buffer that cuts the ready path, flush with priority over stall, and an occupancy output for the flow controller.

Parameters:
- DATA_W, 32, payload width in bits (1..512).
- SKID, 1, 1 = 2-entry skid buffer with registered up_ready_o; 0 = single register with combinational ready.
- RST_VAL, 0, payload value loaded at reset, and at flush when CLR_ON_FLUSH=1 (DATA_W bits).
- CLR_ON_FLUSH, 1, 1 = payload registers load RST_VAL on flush; 0 = payload is kept and only valid bits clear.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, reset: asynchronous, active-low.
- up_valid_i, input, 1, upstream beat valid.
- up_ready_o, output, 1, stage can accept a beat this cycle.
- up_data_i, input, DATA_W, upstream payload.
- dn_valid_o, output, 1, downstream beat valid (= main_valid).
- dn_ready_i, input, 1, downstream can accept.
- dn_data_o, output, DATA_W, downstream payload (= main register).
- stall_i, input, 1, flow-control hold; blocks downstream transfer.
- flush_i, input, 1, kill all held and incoming beats.
- occ_o, output, 2, entries held (0, 1 or 2; 2 only when SKID=1).

Behaviour:
- Internal state: main_valid/main_data; when SKID=1 also skid_valid/skid_data.
- up_fire = up_valid_i & up_ready_o.
- dn_fire = main_valid & dn_ready_i & ~stall_i.
- Reset (async, rst_n=0):
  - main_valid=0, skid_valid=0.
  - main_data=RST_VAL, skid_data=RST_VAL.
  - dn_valid_o=0, dn_data_o=RST_VAL, occ_o=0.
  - up_ready_o=1 when SKID=1; when SKID=0 it follows the combinational formula.
  - Reset mid-transfer drops all beats with no partial update.
- up_ready_o:
  - SKID=1: ~skid_valid & ~flush_i.
  - SKID=0: (~main_valid | dn_fire) & ~flush_i.
  - Flush therefore never completes an upstream handshake.
- Latency: a beat accepted at edge N appears on dn_data_o/dn_valid_o after edge N (1 cycle). There is no combinational path from up_data_i to dn_data_o.
- States for SKID=1, derived from the valid bits:
  - EMPTY: up_fire -> FULL, main<=up_data_i.
  - FULL:
    - up_fire & dn_fire -> FULL, main<=up_data_i.
    - up_fire & ~dn_fire -> SKID, skid<=up_data_i.
    - ~up_fire & dn_fire -> EMPTY.
    - neither -> hold.
  - SKID (up_ready_o=0):
    - dn_fire -> FULL, main<=skid_data, skid_valid<=0.
    - otherwise hold.
- SKID=0: only EMPTY and FULL exist, with the same transitions minus the SKID state; simultaneous up_fire and dn_fire replaces main.
- Flush (priority: reset > flush > stall > normal):
  - Next edge: main_valid=0, skid_valid=0, occ_o=0.
  - Payload loads RST_VAL if CLR_ON_FLUSH=1, else holds.
  - Flush overrides a simultaneous stall or dn_ready_i.
  - dn_fire may still be asserted in the flush cycle; downstream consumes that beat and the stage clears anyway.
- Stall:
  - Blocks dn_fire only.
  - Upstream may still fill EMPTY->FULL, or FULL->SKID when SKID=1.
  - Held payload is bit-stable while stalled.
- Ordering: beats leave strictly in acceptance order; the skid entry is never bypassed.
- occ_o = main_valid + skid_valid. The invariant skid_valid -> main_valid always holds.
- Data registers update only on the transitions above; otherwise they hold (no clock-enable glitches).

Test Plan:
1. Streaming, SKID=1, dn_ready_i=1, stall_i=0. Send beats 0x11, 0x22, 0x33 on consecutive cycles -> the same values appear on dn_data_o one cycle later, back-to-back; up_ready_o stays 1; occ_o=1.
2. Backpressure, SKID=1. Main holds 0xA, then dn_ready_i=0 while 0xB is sent -> occ_o=2 and up_ready_o=0 the next cycle. Raise dn_ready_i -> output 0xA then 0xB in order; occ_o goes 2->1->0.
3. Stall versus fill, SKID=0. Main holds 0x5 and stall_i=1 for 3 cycles -> dn_data_o=0x5 is stable, up_ready_o=0, no beat is lost. Release -> 0x5 consumed, next beat accepted in the same cycle.
4. Flush with stall. Occupancy 2 with stall_i=1; assert flush_i=1 for one cycle -> next cycle dn_valid_o=0, occ_o=0, dn_data_o=RST_VAL (CLR_ON_FLUSH=1); up_ready_o was 0 during flush.
5. Flush with CLR_ON_FLUSH=0 and DATA_W=64. Flush while holding 0xDEADBEEF_CAFEF00D -> dn_valid_o=0 and dn_data_o keeps the value.
6. Async reset mid-burst. Assert rst_n=0 between clock edges -> dn_valid_o and occ_o clear immediately, dn_data_o=RST_VAL. First beat after release passes with 1-cycle latency.
